// File: rtl/cp0_unit.sv
// Coprocessor 0: SR/Cause/EPC/PRId register file with precise exception and
// interrupt entry, eret return, and an immediate request to flush/redirect fetch.
module cp0_unit #(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
    parameter logic [31:0] PRID_VALUE   = 32'h2024_0007
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] cp0_wd,
    input  logic        cp0_we,
    output logic [31:0] cp0_rd,
    input  logic [31:0] vpc,
    input  logic        bd_in,
    input  logic        exc_in,
    input  logic [4:0]  exccode_in,
    input  logic [5:0]  hw_int,
    input  logic        eret,
    output logic        req,
    output logic [31:0] handler_pc,
    output logic [31:0] epc_out
);
    localparam logic [4:0] ADDR_SR    = 5'd12;
    localparam logic [4:0] ADDR_CAUSE = 5'd13;
    localparam logic [4:0] ADDR_EPC   = 5'd14;
    localparam logic [4:0] ADDR_PRID  = 5'd15;

    logic [5:0]  sr_im_q, sr_im_d;
    logic        sr_exl_q, sr_exl_d;
    logic        sr_ie_q, sr_ie_d;
    logic        cause_bd_q, cause_bd_d;
    logic [5:0]  cause_ip_q, cause_ip_d;
    logic [4:0]  cause_exc_q, cause_exc_d;
    logic [31:0] epc_q, epc_d;

    logic int_req;
    logic exc_req;
    logic unused_wd_bits;

    assign unused_wd_bits = ^{cp0_wd[31:16], cp0_wd[9:2]};

    assign int_req = (|(hw_int & sr_im_q)) & sr_ie_q & ~sr_exl_q;
    assign exc_req = exc_in & ~sr_exl_q;
    // Gated by reset so an exception flagged while in reset cannot redirect fetch.
    assign req     = rst & (int_req | exc_req);

    assign handler_pc = HANDLER_ADDR;
    assign epc_out    = epc_q;

    always_comb begin
        sr_im_d     = sr_im_q;
        sr_exl_d    = sr_exl_q;
        sr_ie_d     = sr_ie_q;
        cause_bd_d  = cause_bd_q;
        cause_ip_d  = hw_int;
        cause_exc_d = cause_exc_q;
        epc_d       = epc_q;
        if (req) begin
            sr_exl_d    = 1'b1;
            cause_exc_d = int_req ? 5'd0 : exccode_in;
            cause_bd_d  = bd_in;
            epc_d       = bd_in ? (vpc - 32'd4) : vpc;
        end else begin
            if (cp0_we) begin
                case (cp0_addr)
                    ADDR_SR: begin
                        sr_im_d  = cp0_wd[15:10];
                        sr_exl_d = cp0_wd[1];
                        sr_ie_d  = cp0_wd[0];
                    end
                    ADDR_EPC: epc_d = cp0_wd;
                    default: ;
                endcase
            end
            // eret overrides any EXL value written in the same cycle.
            if (eret) begin
                sr_exl_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_im_q     <= '0;
            sr_exl_q    <= 1'b0;
            sr_ie_q     <= 1'b0;
            cause_bd_q  <= 1'b0;
            cause_ip_q  <= '0;
            cause_exc_q <= '0;
            epc_q       <= '0;
        end else begin
            sr_im_q     <= sr_im_d;
            sr_exl_q    <= sr_exl_d;
            sr_ie_q     <= sr_ie_d;
            cause_bd_q  <= cause_bd_d;
            cause_ip_q  <= cause_ip_d;
            cause_exc_q <= cause_exc_d;
            epc_q       <= epc_d;
        end
    end

    always_comb begin
        cp0_rd = 32'd0;
        case (cp0_addr)
            ADDR_SR:    cp0_rd = {16'd0, sr_im_q, 8'd0, sr_exl_q, sr_ie_q};
            ADDR_CAUSE: cp0_rd = {cause_bd_q, 15'd0, cause_ip_q, 3'd0, cause_exc_q, 2'd0};
            ADDR_EPC:   cp0_rd = epc_q;
            ADDR_PRID:  cp0_rd = PRID_VALUE;
            default:    cp0_rd = 32'd0;
        endcase
    end
endmodule

// File: tb/tb_cp0_unit.sv
// Directed bench for cp0_unit: interrupt/exception entry, masking, eret,
// collisions, wrap-around EPC and asynchronous reset.
module tb_cp0_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wd;
    logic        cp0_we;
    logic [31:0] cp0_rd;
    logic [31:0] vpc;
    logic        bd_in;
    logic        exc_in;
    logic [4:0]  exccode_in;
    logic [5:0]  hw_int;
    logic        eret;
    logic        req;
    logic [31:0] handler_pc;
    logic [31:0] epc_out;

    int checks   = 0;
    int failures = 0;

    cp0_unit dut (
        .clk(clk), .rst(rst), .cp0_addr(cp0_addr), .cp0_wd(cp0_wd), .cp0_we(cp0_we),
        .cp0_rd(cp0_rd), .vpc(vpc), .bd_in(bd_in), .exc_in(exc_in),
        .exccode_in(exccode_in), .hw_int(hw_int), .eret(eret), .req(req),
        .handler_pc(handler_pc), .epc_out(epc_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] a, input string tag, input logic [31:0] exp);
        cp0_addr = a;
        #1;
        check(tag, cp0_rd, exp);
    endtask

    initial begin
        rst = 1'b0; cp0_addr = 5'd0; cp0_wd = '0; cp0_we = 1'b0; vpc = '0;
        bd_in = 1'b0; exc_in = 1'b1; exccode_in = 5'd8; hw_int = '0; eret = 1'b0;
        #2;
        check("rst_req", {31'd0, req}, 32'd0);
        rd(5'd12, "rst_sr", 32'd0);
        rd(5'd15, "rst_prid", 32'h2024_0007);
        check("handler_pc", handler_pc, 32'h0000_4180);
        step(); step();
        exc_in = 1'b0;
        rst = 1'b1;

        // mtc0 SR: same-cycle read is old, next cycle new
        cp0_we = 1'b1; cp0_addr = 5'd12; cp0_wd = 32'h0000_0401;
        #1; check("sr_old", cp0_rd, 32'd0);
        step(); cp0_we = 1'b0;
        rd(5'd12, "sr_new", 32'h0000_0401);

        // Interrupt entry
        hw_int = 6'b000001; vpc = 32'h0000_3010;
        #1; check("int_req", {31'd0, req}, 32'd1);
        step();
        rd(5'd14, "int_epc", 32'h0000_3010);
        rd(5'd13, "int_cause", 32'h0000_0400);
        rd(5'd12, "int_sr", 32'h0000_0403);
        check("int_req_after", {31'd0, req}, 32'd0);

        // Masking while EXL=1
        hw_int = 6'b000100; exc_in = 1'b1; exccode_in = 5'd10;
        #1; check("mask_req", {31'd0, req}, 32'd0);
        step(); exc_in = 1'b0;
        rd(5'd13, "mask_cause", 32'h0000_1000);
        check("mask_epc", epc_out, 32'h0000_3010);

        // eret with pending enabled interrupt
        hw_int = 6'b000001; eret = 1'b1;
        #1; check("eret_req_before", {31'd0, req}, 32'd0);
        step(); eret = 1'b0;
        rd(5'd12, "eret_sr", 32'h0000_0401);
        check("eret_epc", epc_out, 32'h0000_3010);
        check("eret_pending_req", {31'd0, req}, 32'd1);
        vpc = 32'h0000_3020;
        step(); hw_int = '0;
        check("int2_epc", epc_out, 32'h0000_3020);
        eret = 1'b1; step(); eret = 1'b0;

        // Delay-slot exception
        exc_in = 1'b1; exccode_in = 5'd4; bd_in = 1'b1; vpc = 32'h0000_3004;
        #1; check("ds_req", {31'd0, req}, 32'd1);
        step(); exc_in = 1'b0; bd_in = 1'b0;
        rd(5'd14, "ds_epc", 32'h0000_3000);
        rd(5'd13, "ds_cause", 32'h8000_0010);

        // eret + SR write: write applies, EXL ends 0
        eret = 1'b1; cp0_we = 1'b1; cp0_addr = 5'd12; cp0_wd = 32'h0000_0803;
        step(); eret = 1'b0; cp0_we = 1'b0;
        rd(5'd12, "eret_wr_sr", 32'h0000_0801);

        // Collision: exception beats eret and EPC write
        exc_in = 1'b1; exccode_in = 5'd5; eret = 1'b1; cp0_we = 1'b1;
        cp0_addr = 5'd14; cp0_wd = 32'hDEAD_BEEF; vpc = 32'h0000_3040;
        step(); exc_in = 1'b0; eret = 1'b0; cp0_we = 1'b0;
        rd(5'd13, "col_cause", 32'h0000_0014);
        rd(5'd12, "col_sr", 32'h0000_0803);
        rd(5'd14, "col_epc", 32'h0000_3040);
        eret = 1'b1; step(); eret = 1'b0;

        // Interrupt wins over exception; delay slot at PC 0 wraps
        hw_int = 6'b000010; exc_in = 1'b1; exccode_in = 5'd12; bd_in = 1'b1; vpc = 32'd0;
        step(); exc_in = 1'b0; bd_in = 1'b0; hw_int = '0;
        rd(5'd13, "prio_cause", 32'h8000_0800);
        rd(5'd14, "wrap_epc", 32'hFFFF_FFFC);

        // Cause is read-only; unmapped reads 0
        eret = 1'b1; cp0_we = 1'b1; cp0_addr = 5'd13; cp0_wd = 32'hFFFF_FFFF;
        step(); eret = 1'b0; cp0_we = 1'b0;
        rd(5'd13, "cause_ro", 32'h8000_0000);
        rd(5'd3, "unmapped", 32'd0);

        // Async reset mid-cycle after an exception
        exc_in = 1'b1; exccode_in = 5'd8; vpc = 32'h0000_3100;
        step(); exc_in = 1'b0;
        rd(5'd14, "pre_rst_epc", 32'h0000_3100);
        rst = 1'b0;
        rd(5'd12, "arst_sr", 32'd0);
        rd(5'd13, "arst_cause", 32'd0);
        rd(5'd14, "arst_epc", 32'd0);
        rd(5'd15, "arst_prid", 32'h2024_0007);

        // Request during reset is discarded; first edge after release takes it
        exc_in = 1'b1; exccode_in = 5'd12;
        #1; check("rst_req_gate", {31'd0, req}, 32'd0);
        step();
        rd(5'd13, "rst_discard", 32'd0);
        rst = 1'b1;
        #1; check("post_rst_req", {31'd0, req}, 32'd1);
        step(); exc_in = 1'b0;
        rd(5'd13, "post_rst_cause", 32'h0000_0030);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cp0_unit.md
CP0_UNIT -- requirements
Module: cp0_unit

Interface
REQ-001 SHALL provide parameter HANDLER_ADDR, default 32'h0000_4180, exception handler entry PC.
REQ-002 SHALL provide parameter PRID_VALUE, default 32'h2024_0007, read-only processor ID value.
REQ-003 SHALL have port clk  in  1  single system clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port cp0_addr  in  5  register select: 12=SR, 13=Cause, 14=EPC, 15=PRId.
REQ-006 SHALL have port cp0_wd  in  32  mtc0 write data.
REQ-007 SHALL have port cp0_we  in  1  mtc0 write enable.
REQ-008 SHALL have port cp0_rd  out  32  mfc0 read data.
REQ-009 SHALL have port vpc  in  32  PC of the instruction currently in the M stage.
REQ-010 SHALL have port bd_in  in  1  the M-stage instruction is in a branch delay slot.
REQ-011 SHALL have port exc_in  in  1  synchronous exception flagged by the M stage or the bus bridge.
REQ-012 SHALL have port exccode_in  in  5  code for exc_in (AdEL=4, AdES=5, RI=10, Ov=12, Syscall=8).
REQ-013 SHALL have port hw_int  in  6  device interrupt sources from the bridge: [0] Timer0, [1] Timer1, [2] IntGen, [5:3] tied 0.
REQ-014 SHALL have port eret  in  1  eret in the M stage.
REQ-015 SHALL have port req  out  1  flush pipeline and redirect fetch.
REQ-016 SHALL have port handler_pc  out  32  equals HANDLER_ADDR.
REQ-017 SHALL have port epc_out  out  32  current EPC contents, used as the eret target.

Function
REQ-018 SR field layout SHALL be IM=[15:10], EXL=[1], IE=[0]; all other bits SHALL read 0 and ignore writes.
REQ-019 Cause field layout SHALL be BD=[31], IP=[15:10], ExcCode=[6:2]; all other bits SHALL read 0.
REQ-020 Cause.IP SHALL be loaded from hw_int on every clock edge, regardless of other events.
REQ-021 int_req SHALL equal (|(hw_int & SR.IM)) & SR.IE & !SR.EXL. It SHALL be combinational, with zero-cycle latency.
REQ-022 exc_req SHALL equal exc_in & !SR.EXL.
REQ-023 req SHALL equal int_req | exc_req. It SHALL be combinational and SHALL be asserted in the same cycle as the cause.
REQ-024 When int_req and exc_req are both true, the interrupt SHALL win and ExcCode SHALL be 0.
REQ-025 On an edge with req=1, the block SHALL:
- set EXL to 1;
- load ExcCode (0 for an interrupt, otherwise exccode_in);
- load BD from bd_in;
- load EPC with (bd_in ? vpc-4 : vpc), using 32-bit wrap-around arithmetic.
REQ-026 On an edge with req=1, any simultaneous cp0_we write and any simultaneous eret SHALL be ignored.
REQ-027 On an edge with req=0 and eret=1, EXL SHALL clear to 0. A same-cycle cp0_we write SHALL still apply, except that SR.EXL SHALL end at 0.
REQ-028 On an edge with req=0 and cp0_we=1, the selected writable field SHALL update. Cause and PRId SHALL be read-only to mtc0. EPC writes SHALL store all 32 bits.
REQ-029 cp0_rd SHALL be combinational on cp0_addr and SHALL reflect the registered state. Unmapped addresses SHALL read 0.
REQ-030 A write followed by a read on the next cycle SHALL return the new value. A same-cycle read SHALL return the old value.
REQ-031 While EXL=1, interrupts and exceptions SHALL be masked (no nesting). Cause.IP SHALL keep tracking hw_int.
REQ-032 epc_out SHALL always equal the EPC register.

Reset
REQ-033 While rst=0, the block SHALL immediately force SR=0, Cause=0, EPC=0, req=0 and cp0_rd=0 for the mapped SR, Cause and EPC addresses. PRId SHALL still read PRID_VALUE.
REQ-034 A reset asserted on the same edge as a req SHALL discard the event. The first req SHALL be possible on the first edge after rst rises.

Verification
REQ-035 Interrupt path: mtc0 SR=32'h0000_0401, then hw_int=6'b000001 with vpc=32'h0000_3010 -> req=1 the same cycle; next cycle EPC=32'h0000_3010, Cause=32'h0000_0400, SR.EXL=1, req=0.
REQ-036 Delay-slot exception: exc_in=1, exccode_in=4, bd_in=1, vpc=32'h0000_3004 -> EPC=32'h0000_3000, Cause=32'h8000_0010.
REQ-037 Masking: with SR.EXL=1, raise hw_int=6'b000100 and exc_in=1 -> req=0; Cause.IP=6'b000100 after one edge; EPC unchanged.
REQ-038 Collision: in the same cycle, exc_in=1, exccode=5, eret=1, cp0_we=1 to EPC with 32'hDEAD_BEEF -> exception recorded (ExcCode=5, EXL=1); EPC=vpc; the write is dropped.
REQ-039 eret: with EXL=1, pulse eret -> EXL=0 next cycle; epc_out unchanged; a pending enabled interrupt asserts req in the following cycle.
REQ-040 Async reset: drop rst mid-cycle after an exception -> SR, Cause and EPC read 0 before the next edge; PRId reads 32'h2024_0007.
